sumsq_int: RTL and testbench
============================

SUMSQ_INT -- requirements
Module: sumsq_int

Interface
REQ-001 Parameter: IN_W, default 3, operand width in bits; SHALL be >= 2.
REQ-002 Parameter: OUT_W, fixed at 2*IN_W+2, result width; always even so the result can drive sqrt_int radicand WIDTH directly (default 8).
REQ-003 Port: clk  input  1  sole clock, rising-edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  sampled at each rising edge; launches a calculation.
REQ-006 Port: a  input  IN_W  unsigned operand A; sampled only on the start edge.
REQ-007 Port: b  input  IN_W  unsigned operand B; sampled only on the start edge.
REQ-008 Port: busy  output  1  calculation in progress.
REQ-009 Port: valid  output  1  sum is valid; level, held until the next start or reset.
REQ-010 Port: sum  output  OUT_W  a*a + b*b, zero-extended.
REQ-011 Port: sq_start  output  1  one-cycle pulse for the downstream sqrt_int start input.

Function
REQ-012 States: IDLE, SQ_A, SQ_B.
REQ-013 Start edge, any state: latch a and b; acc <= 0; cnt <= 0; state <= SQ_A; busy <= 1; valid <= 0; sq_start <= 0.
REQ-014 A start arriving mid-calculation SHALL abort the current calculation and restart with the new operands; no valid and no sq_start are produced for the aborted one.
REQ-015 SQ_A edge: if the multiplier LSB is 1, add the multiplicand (shifted left by cnt) to acc; shift the multiplier right; cnt++.
REQ-016 SQ_A -> SQ_B when cnt == IN_W-1 on that edge; cnt <= 0; multiplicand and multiplier reload from latched b.
REQ-017 SQ_B edge: same shift-add step as SQ_A, accumulating into the same acc.
REQ-018 SQ_B -> IDLE when cnt == IN_W-1 on that edge; on that edge: busy <= 0, valid <= 1, sum <= final acc, sq_start <= 1.
REQ-019 Latency: with start sampled at edge 0, valid and sq_start are high after edge 2*IN_W (6 for the default); throughput is one result per 2*IN_W+1 cycles.
REQ-020 sq_start SHALL be high for exactly one cycle per completed calculation; it is coincident with the rising edge of valid.
REQ-021 sum SHALL change only on a completing edge; between completions it holds its last value.
REQ-022 acc width SHALL be OUT_W; the maximum value 2*(2^IN_W-1)^2 fits with no overflow; no truncation or saturation logic.
REQ-023 IDLE with start low: all registers hold.
REQ-024 Operands of 0: the full 2*IN_W cycles still elapse; there is no early termination.

Reset
REQ-025 While rst_n is low: state = IDLE, busy = 0, valid = 0, sq_start = 0, sum = 0, acc = 0, cnt = 0, latched operands = 0.
REQ-026 Reset asserted mid-calculation SHALL abort it immediately (asynchronously); the first start sampled after rst_n deasserts begins a clean calculation.
REQ-027 start is ignored on any edge at which rst_n is low.

Structure
REQ-028 Shared package sumsq_pkg holds the state enum type and the OUT_W width function/constant.
REQ-029 No sub-module: one shift-add datapath is time-shared for both squares. The counter is $clog2(IN_W) bits wide, minimum 1.
REQ-030 The block connects directly: sum -> sqrt_int.rad and sq_start -> sqrt_int.start, with equal WIDTH parameters.

Verification
REQ-031 a=3, b=4, start for 1 cycle -> after 6 edges, valid=1, sum=25, sq_start pulses once; a chained sqrt_int then yields root=5, rem=0.
REQ-032 a=7, b=7 (maximum operands) -> sum=98, no overflow; a=0, b=0 -> sum=0 after the full 6 cycles.
REQ-033 start with a=5, b=1, then a second start at edge 3 with a=2, b=2 -> a single completion 6 edges after the second start, sum=8; no sq_start pulse for the first calculation.
REQ-034 rst_n low at edge 4 of a calculation -> busy, valid, sq_start and sum all 0 at once; start after release with a=1, b=2 -> sum=5.
REQ-035 After completion, hold start low for 10 cycles -> valid stays 1, sum is stable, sq_start does not pulse again; a new start drops valid on that edge.
REQ-036 Random sweep over all 64 (a, b) pairs -> sum == a*a + b*b and sq_start pulse count == 64.

Source files
------------

// File: rtl/sumsq_pkg.sv
// Shared types and width helpers for the sum-of-squares block.
package sumsq_pkg;

    localparam int SUMSQ_IN_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ_A = 2'd1,
        ST_SQ_B = 2'd2
    } sumsq_state_e;

    // Two extra bits hold 2*(2^IN_W-1)^2 and keep the width even for the root stage.
    function automatic int sumsq_out_w(input int in_w);
        return 2 * in_w + 2;
    endfunction

    function automatic int sumsq_cnt_w(input int in_w);
        return (in_w > 1) ? $clog2(in_w) : 1;
    endfunction

endpackage

// File: rtl/sumsq_int.sv
// Computes a*a + b*b with one shift-add multiplier reused for both squares,
// then raises valid and a one-cycle sq_start pulse for a chained sqrt_int.
//
// state   | meaning
// IDLE    | waiting; valid and sum hold the last completed result
// SQ_A    | shift-add steps accumulating a*a
// SQ_B    | shift-add steps accumulating b*b into the same acc
module sumsq_int
    import sumsq_pkg::*;
#(
    parameter int IN_W  = SUMSQ_IN_W_DEF,
    parameter int OUT_W = sumsq_out_w(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] sum,
    output logic             sq_start
);

    localparam int CNT_W = sumsq_cnt_w(IN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    sumsq_state_e     state_q, state_d;
    logic [IN_W-1:0]  a_q, a_d;
    logic [IN_W-1:0]  b_q, b_d;
    logic [IN_W-1:0]  mplier_q, mplier_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] sum_q, sum_d;
    logic             sq_start_q, sq_start_d;

    logic [IN_W-1:0]  mcand;
    logic [OUT_W-1:0] addend;
    logic [OUT_W-1:0] acc_step;
    logic             last_step;

    // The multiplicand is the latched operand itself; only the multiplier shifts.
    assign mcand     = (state_q == ST_SQ_B) ? b_q : a_q;
    assign addend    = mplier_q[0] ? (OUT_W'(mcand) << cnt_q) : '0;
    assign acc_step  = acc_q + addend;
    assign last_step = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            sum_q      <= '0;
            sq_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            sum_q      <= sum_d;
            sq_start_q <= sq_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        sum_d      = sum_q;
        sq_start_d = 1'b0;

        if (start) begin
            // A start in any state discards whatever was in flight.
            a_d      = a;
            b_d      = b;
            mplier_d = a;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_SQ_A;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_SQ_A: begin
                    acc_d    = acc_step;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_step) begin
                        state_d  = ST_SQ_B;
                        cnt_d    = '0;
                        mplier_d = b_q;
                    end
                end
                ST_SQ_B: begin
                    acc_d    = acc_step;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_step) begin
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                        busy_d     = 1'b0;
                        valid_d    = 1'b1;
                        sum_d      = acc_step;
                        sq_start_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign sum      = sum_q;
    assign sq_start = sq_start_q;

endmodule

// File: tb/tb_sumsq_int.sv
// Self-checking bench for sumsq_int: directed cases plus a shuffled sweep of all operand pairs.
module tb_sumsq_int;

    localparam int IN_W  = 3;
    localparam int OUT_W = 2 * IN_W + 2;
    localparam int LAT   = 2 * IN_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] sum;
    logic             sq_start;

    int checks;
    int errors;
    int pulses;

    sumsq_int #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .valid    (valid),
        .sum      (sum),
        .sq_start (sq_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (sq_start === 1'b1) pulses++;

    function automatic logic [OUT_W-1:0] ref_sum(input int av, input int bv);
        return OUT_W'(av * av + bv * bv);
    endfunction

    task automatic launch(input int av, input int bv);
        @(negedge clk);
        start = 1'b1;
        a     = IN_W'(av);
        b     = IN_W'(bv);
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        assert (busy === 1'b1 && valid === 1'b0)
        else begin
            errors++;
            $error("FAIL launch busy=%0b valid=%0b expected busy=1 valid=0", busy, valid);
        end
    endtask

    task automatic wait_done(input int av, input int bv);
        int lat;
        logic [OUT_W-1:0] exp_v;
        exp_v = ref_sum(av, bv);
        lat = 0;
        while (valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        assert (lat === LAT)
        else begin
            errors++;
            $error("FAIL latency a=%0d b=%0d got %0d expected %0d", av, bv, lat, LAT);
        end
        checks++;
        assert (sum === exp_v)
        else begin
            errors++;
            $error("FAIL sum a=%0d b=%0d got %0d expected %0d", av, bv, sum, exp_v);
        end
        checks++;
        assert (sq_start === 1'b1 && busy === 1'b0)
        else begin
            errors++;
            $error("FAIL done_flags sq_start=%0b busy=%0b expected 1 0", sq_start, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        assert (sq_start === 1'b0 && valid === 1'b1 && sum === exp_v)
        else begin
            errors++;
            $error("FAIL after_done sq_start=%0b valid=%0b sum=%0d expected 0 1 %0d",
                   sq_start, valid, sum, exp_v);
        end
    endtask

    task automatic calc(input int av, input int bv);
        launch(av, bv);
        wait_done(av, bv);
    endtask

    initial begin
        int p0;
        int order[64];
        int j;
        int tmp;

        checks = 0;
        errors = 0;
        pulses = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (busy === 1'b0 && valid === 1'b0 && sq_start === 1'b0 && sum === '0)
        else begin
            errors++;
            $error("FAIL reset busy=%0b valid=%0b sq_start=%0b sum=%0d expected all 0",
                   busy, valid, sq_start, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic, maximum and zero operands
        p0 = pulses;
        calc(3, 4);
        calc(7, 7);
        calc(0, 0);
        checks++;
        assert (pulses - p0 === 3)
        else begin
            errors++;
            $error("FAIL pulse_count_basic got %0d expected 3", pulses - p0);
        end

        // Hold after completion: valid and sum stay, no extra pulse
        calc(3, 4);
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            assert (valid === 1'b1 && sum === ref_sum(3, 4) && busy === 1'b0)
            else begin
                errors++;
                $error("FAIL hold cycle %0d valid=%0b sum=%0d expected 1 %0d",
                       i, valid, sum, ref_sum(3, 4));
            end
        end
        checks++;
        assert (pulses === p0)
        else begin
            errors++;
            $error("FAIL hold_pulses got %0d expected %0d", pulses, p0);
        end

        // Restart at edge 3 aborts the first calculation
        p0 = pulses;
        launch(5, 1);
        repeat (2) @(posedge clk);
        #1;
        launch(2, 2);
        wait_done(2, 2);
        checks++;
        assert (pulses - p0 === 1)
        else begin
            errors++;
            $error("FAIL abort_pulses got %0d expected 1", pulses - p0);
        end

        // Async reset mid-calculation, start ignored while in reset
        p0 = pulses;
        launch(3, 4);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (busy === 1'b0 && valid === 1'b0 && sq_start === 1'b0 && sum === '0)
        else begin
            errors++;
            $error("FAIL async_reset busy=%0b valid=%0b sq_start=%0b sum=%0d expected all 0",
                   busy, valid, sq_start, sum);
        end
        @(negedge clk);
        start = 1'b1;
        a     = 3'd6;
        b     = 3'd6;
        @(posedge clk);
        #1;
        checks++;
        assert (busy === 1'b0)
        else begin
            errors++;
            $error("FAIL start_in_reset busy=%0b expected 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        calc(1, 2);
        checks++;
        assert (pulses - p0 === 1)
        else begin
            errors++;
            $error("FAIL reset_pulses got %0d expected 1", pulses - p0);
        end

        // Shuffled sweep over every (a, b) pair
        for (int i = 0; i < 64; i++) order[i] = i;
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        p0 = pulses;
        for (int i = 0; i < 64; i++) begin
            calc(order[i] / 8, order[i] % 8);
        end
        checks++;
        assert (pulses - p0 === 64)
        else begin
            errors++;
            $error("FAIL sweep_pulses got %0d expected 64", pulses - p0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
